ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of received bytes buffered; power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 4, consecutive equal synchronized scl samples needed before the filtered scl level changes; 1..16.
REQ-003 Parameter TIMEOUT_CYC, default 50000, clk cycles without a filtered scl falling edge before a partial frame is abandoned; >= 16.
REQ-004 Parameter CHECK_PARITY, default 1, 1 = odd-parity errors discard the frame, 0 = parity ignored but still reported.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 scl  input  1  PS/2 clock line, asynchronous to clk.
REQ-008 sda  input  1  PS/2 data line, asynchronous to clk.
REQ-009 out_data  output  8  byte at FIFO head, LSB = first data bit received.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-012 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 parity_err  output  1  one-cycle pulse on frame with bad odd parity.
REQ-014 frame_err  output  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
REQ-015 overflow  output  1  sticky; set when a good frame is dropped because FIFO full; cleared only by rst.

Function
REQ-016 scl and sda each SHALL pass through a 2-flop synchronizer; filtered scl SHALL change only after FILTER_LEN consecutive identical synchronized samples.
REQ-017 A bit event SHALL be a 1->0 transition of filtered scl; synchronized sda SHALL be sampled in the cycle the event is detected.
REQ-018 FSM states: IDLE, DATA, PARITY, STOP; each transition occurs only on a bit event, except timeout.
REQ-019 IDLE: event with sda=0 -> DATA, bit counter=0, parity accumulator cleared; event with sda=1 -> frame_err pulse, stay IDLE.
REQ-020 DATA: shift sda into shift register LSB-first, XOR into accumulator; after 8th bit -> PARITY.
REQ-021 PARITY: store parity bit -> STOP; parity good iff XOR of 8 data bits and parity bit = 1.
REQ-022 STOP: sda=1 and (parity good or CHECK_PARITY=0) -> push byte, -> IDLE; sda=0 -> frame_err pulse, no push, -> IDLE.
REQ-023 Bad parity SHALL pulse parity_err in the STOP-event cycle regardless of CHECK_PARITY; with CHECK_PARITY=1 byte is not pushed.
REQ-024 A timeout counter SHALL reset on every bit event and count while state != IDLE; reaching TIMEOUT_CYC -> frame_err pulse, -> IDLE, partial byte discarded.
REQ-025 Push SHALL occur in the cycle after STOP-event detection; out_valid SHALL rise the following cycle when FIFO was empty (first-word-fall-through).
REQ-026 Pop SHALL occur when out_valid && out_ready; out_ready while empty has no effect; out_data holds last value when empty.
REQ-027 Push while full and no pop same cycle: byte dropped, overflow set, level unchanged.
REQ-028 Push and pop same cycle: both performed, level unchanged, including when full.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or underflow below 0.
REQ-030 parity_err and frame_err SHALL each be high for exactly one clk cycle per offending frame, never both for the same frame event.

Reset
REQ-031 While rst=1: FSM=IDLE, bit counter, timeout counter, pointers, level=0; out_valid=0, out_data=0, parity_err=0, frame_err=0, overflow=0; synchronizer and filter flops loaded with 1 (bus idle).
REQ-032 rst asserted mid-frame SHALL discard the partial frame with no error pulse; reception resumes with next start bit after rst deasserts.

Verification
REQ-033 Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), out_ready=1 -> out_data=0x1C, out_valid for 1 cycle, level back to 0, no error pulses.
REQ-034 Frame 0xF0 with parity bit 0 (bad), CHECK_PARITY=1 -> parity_err one pulse, no push, level=0; repeat with CHECK_PARITY=0 -> parity_err pulse and 0xF0 pushed.
REQ-035 FIFO_DEPTH=8, out_ready=0, send 9 good frames 0x01..0x09 -> level=8, overflow=1, then drain yields 0x01..0x08 in order.
REQ-036 Send start + 4 data bits then stop toggling scl -> after TIMEOUT_CYC cycles frame_err one pulse, FSM IDLE; next full frame 0x5A received correctly.
REQ-037 scl glitch low for FILTER_LEN-1 cycles mid-frame -> no bit event, frame 0x3C received intact; stop bit 0 -> frame_err pulse, no push.
REQ-038 FIFO full, push and pop in same cycle -> level stays 8, overflow stays 0, newest byte appears after the 7 older bytes.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: sync + glitch-filtered scl, 11-bit frame FSM, FWFT byte FIFO.
// Latency: byte is written 1 clk after the stop-bit event; out_valid follows 1 clk later.
// Backpressure: out_valid/out_ready; a good frame arriving while full is dropped and sets sticky overflow.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH   = 8,
  parameter int FILTER_LEN   = 4,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int CHECK_PARITY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl,
  input  logic                        sda,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = 5;
  localparam logic [FW-1:0] FL_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          scl_s1, scl_s2, sda_s1, sda_s2;
  logic          scl_f, scl_f_d;
  logic [FW-1:0] fcnt;
  logic          bit_evt;
  logic          sda_bit;

  state_t        state, state_n;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par_acc;
  logic          par_bit;
  logic          par_ok;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          push_c, parity_err_c, frame_err_c;
  logic          push_q;
  logic [7:0]    push_dat;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0]    last_dat;
  logic          full, pop, wr, ovf_set;

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

  // scl glitch filter: level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f   <= 1'b1;
      scl_f_d <= 1'b1;
      fcnt    <= '0;
    end else begin
      scl_f_d <= scl_f;
      if (scl_s2 == scl_f) begin
        fcnt <= '0;
      end else if (fcnt == FL_LAST) begin
        scl_f <= scl_s2;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign bit_evt = scl_f_d & ~scl_f;
  assign sda_bit = sda_s2;
  assign par_ok  = par_acc ^ par_bit;
  assign timeout = (state != IDLE) && (tcnt == TO_LAST);

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-event decisions; a bad stop bit reports as frame error only.
  always_comb begin
    state_n      = state;
    push_c       = 1'b0;
    parity_err_c = 1'b0;
    frame_err_c  = 1'b0;
    if (bit_evt) begin
      case (state)
        IDLE: begin
          if (!sda_bit) state_n = DATA;
          else          frame_err_c = 1'b1;
        end
        DATA: begin
          if (bcnt == 3'd7) state_n = PARITY;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!sda_bit) begin
            frame_err_c = 1'b1;
          end else begin
            parity_err_c = ~par_ok;
            push_c       = par_ok || (CHECK_PARITY == 0);
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n     = IDLE;
      frame_err_c = 1'b1;
    end
  end

  assign parity_err = parity_err_c & ~rst;
  assign frame_err  = frame_err_c & ~rst;

  // Frame datapath: shift register, parity, bit counter, inactivity timer, push stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_bit  <= 1'b0;
      tcnt     <= '0;
      push_q   <= 1'b0;
      push_dat <= '0;
    end else begin
      push_q <= push_c;
      if (push_c) push_dat <= shreg;
      if (bit_evt || state == IDLE || timeout) tcnt <= '0;
      else                                     tcnt <= tcnt + 1'b1;
      if (bit_evt) begin
        case (state)
          IDLE: begin
            bcnt    <= '0;
            par_acc <= 1'b0;
          end
          DATA: begin
            shreg   <= {sda_bit, shreg[7:1]};
            par_acc <= par_acc ^ sda_bit;
            bcnt    <= bcnt + 1'b1;
          end
          PARITY:  par_bit <= sda_bit;
          default: ;
        endcase
      end
    end
  end

  assign full    = (level == FULL_LVL);
  assign pop     = out_valid & out_ready;
  assign wr      = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  // FIFO pointers, occupancy, sticky overflow and last-popped byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      last_dat <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr     <= rptr + 1'b1;
        last_dat <= mem[rptr];
      end
      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because out_valid guards the read.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_dat;
  end

  assign out_valid = (level != '0) & ~rst;
  assign out_data  = rst ? 8'h00 : (out_valid ? mem[rptr] : last_dat);

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int TO    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] out_data, np_data;
  logic       out_valid, np_valid;
  logic [3:0] level, np_level;
  logic       parity_err, frame_err, overflow;
  logic       np_perr, np_ferr, np_ovf;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .CHECK_PARITY(1)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .out_data(out_data), .out_valid(out_valid), .out_ready(rdy), .level(level),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow));

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .CHECK_PARITY(0)) dut_np (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .out_data(np_data), .out_valid(np_valid), .out_ready(1'b1), .level(np_level),
    .parity_err(np_perr), .frame_err(np_ferr), .overflow(np_ovf));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] np_q[$];
  int perr_cnt = 0, ferr_cnt = 0, np_perr_cnt = 0, vld_cycles = 0;
  int exp_perr = 0, exp_ferr = 0, exp_np_perr = 0;
  logic [7:0] e_dut, e_np;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard: pops expected bytes whenever a DUT transfers a byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) vld_cycles++;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut_unexpected_pop: got 0x%0h expected no byte", out_data);
        end else begin
          e_dut = exp_q.pop_front();
          check("dut_data", {24'h0, out_data}, {24'h0, e_dut});
        end
      end
      if (np_valid) begin
        if (np_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL np_unexpected_pop: got 0x%0h expected no byte", np_data);
        end else begin
          e_np = np_q.pop_front();
          check("np_data", {24'h0, np_data}, {24'h0, e_np});
        end
      end
      if (parity_err) perr_cnt++;
      if (frame_err)  ferr_cnt++;
      if (np_perr)    np_perr_cnt++;
      if (parity_err && frame_err) begin
        n_chk++; n_fail++;
        $display("FAIL both_err: got parity_err=1 frame_err=1 expected at most one");
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    wait_cyc(10);
    scl = 1'b0;
    wait_cyc(20);
    scl = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_bit_glitch(input logic b);
    sda = b;
    wait_cyc(4);
    scl = 1'b0;
    wait_cyc(FL - 1);
    scl = 1'b1;
    wait_cyc(4);
    scl = 1'b0;
    wait_cyc(20);
    scl = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) send_bit_glitch(d[i]);
      else                 send_bit(d[i]);
    end
    send_bit(par);
    send_bit(stop);
    sda = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, -1);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_perr"}, perr_cnt, exp_perr);
    check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    check({tag, "_np_perr"}, np_perr_cnt, exp_np_perr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(4);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", out_data, 0);
    check("rst_errs", {parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    rdy = 1'b1;
    wait_cyc(20);

    // Single good frame, immediate consumption.
    vld_cycles = 0;
    exp_q.push_back(8'h1C); np_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("1c_level", level, 0);
    check("1c_vld_cycles", vld_cycles, 1);
    check_errs("1c");

    // Bad parity: dropped with checking, delivered without.
    np_q.push_back(8'hF0);
    exp_perr++; exp_np_perr++;
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    check("f0_level", level, 0);
    check_errs("f0");

    // Start bit sampled high.
    exp_ferr++;
    send_bit(1'b1);
    check_errs("badstart");

    // Overflow: nine frames into an eight-deep FIFO with no consumer.
    rdy = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      np_q.push_back(8'(i));
      send_good(8'(i));
    end
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    rdy = 1'b1;
    wait_cyc(20);
    check("drain_level", level, 0);
    check("drain_q", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame discards silently.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    sda = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    check("midrst_ovf", overflow, 0);
    check("midrst_level", level, 0);
    check_errs("midrst");

    // Timeout after start + 4 data bits, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    exp_ferr++;
    wait_cyc(TO + 20);
    check_errs("timeout");
    exp_q.push_back(8'h5A); np_q.push_back(8'h5A);
    send_good(8'h5A);
    check_errs("5a");

    // Short scl glitch is ignored; then a bad stop bit.
    exp_q.push_back(8'h3C); np_q.push_back(8'h3C);
    send_frame(8'h3C, ~^8'h3C, 1'b1, 3);
    check_errs("glitch");
    exp_ferr++;
    send_frame(8'h3C, ~^8'h3C, 1'b0, -1);
    check("badstop_level", level, 0);
    check_errs("badstop");

    // Full FIFO with a simultaneous push and pop on the stop event.
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h11 + 8'(i)); np_q.push_back(8'h11 + 8'(i));
      send_good(8'h11 + 8'(i));
    end
    check("full_level", level, 8);
    exp_q.push_back(8'h19); np_q.push_back(8'h19);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'((8'h19 >> i) & 8'h01));
    send_bit(~^8'h19);
    sda = 1'b1;
    wait_cyc(10);
    scl = 1'b0;
    wait_cyc(7);
    rdy = 1'b1;
    wait_cyc(1);
    rdy = 1'b0;
    wait_cyc(12);
    scl = 1'b1;
    wait_cyc(10);
    check("pp_level", level, 8);
    check("pp_ovf", overflow, 0);
    check("pp_pending", exp_q.size(), 8);
    rdy = 1'b1;
    wait_cyc(20);
    check("final_level", level, 0);
    check("final_q", exp_q.size(), 0);
    check("final_np_q", np_q.size(), 0);
    check_errs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
